dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port data memory between two requesters: the MIPS core's data
//   port (CPU) and a video/debug DMA port (VID).
//   Sits between the core and the data memory instance in the top level.
//   Fair round-robin grant, one transaction in flight, req/ack handshake on every side.
//   Watchdog timeout so a memory that never acks cannot hang either requester.
// PARAMETERS
//   AW       8    address width to memory (word address bits actually used)
//   TIMEOUT  16   cycles in BUSY without mem_ack before forced completion (>=2)
//   ERR_DATA 32'hDEADBEEF  read data returned on timeout
// PORTS
//   clk        in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-high reset
//   cpu_req    in   1   CPU request; held high until cpu_ack seen
//   cpu_wr_en  in   1   1=write, 0=read; stable while cpu_req high
//   cpu_addr   in   AW  CPU address
//   cpu_wdata  in   32  CPU write data
//   cpu_rdata  out  32  read data to CPU, valid while cpu_ack high
//   cpu_ack    out  1   one-cycle completion pulse to CPU
//   vid_req, vid_wr_en, vid_addr, vid_wdata, vid_rdata, vid_ack: same as cpu_* for VID
//   mem_req    out  1   request to memory
//   mem_wr_en  out  1   write strobe to memory (only while mem_req high)
//   mem_addr   out  AW  registered address to memory
//   mem_wdata  out  32  registered write data to memory
//   mem_rdata  in   32  memory read data, valid when mem_ack high
//   mem_ack    in   1   memory completion
//   timeout_err out 1   sticky: set on any timeout, cleared only by reset
// BEHAVIOUR
//   Reset (async): state=IDLE, last_grant=VID, all outputs 0, rdata regs 0, counter 0.
//   FSM states: IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: sample reqs at clk edge. Only one high -> grant it. Both high -> grant the
//     one NOT equal to last_grant (CPU wins first after reset). Neither -> stay IDLE.
//     On grant: latch wr_en/addr/wdata of winner into mem_* regs, owner<=winner,
//     last_grant<=winner, cnt<=0, state<=BUSY.
//   BUSY: mem_req=1, mem_wr_en=latched wr_en. cnt increments each cycle.
//     mem_ack=1 -> owner rdata reg<=mem_rdata (reads; writes leave rdata unchanged),
//       state<=DONE.
//     else cnt==TIMEOUT-1 -> owner rdata<=ERR_DATA, timeout_err<=1, state<=DONE.
//     mem_ack and timeout same cycle -> mem_ack wins, no error.
//   DONE: mem_req=0; owner's *_ack=1 for exactly this cycle; other ack stays 0.
//     Requests ignored in DONE (requester drops req on the cycle it sees ack);
//     next edge -> IDLE.
//   Latency: req high at edge N -> mem_req from N+1; mem_ack at edge M -> ack high
//     during cycle after M. Zero-wait memory: req edge N, ack cycle N+2; min
//     spacing between grants = 3 cycles.
//   Inputs from non-owner are never forwarded; mem_* regs change only in IDLE grant.
//   *_rdata held between transactions (not cleared after ack).
//   Reset mid-transaction: abort immediately, no ack emitted, memory sees mem_req
//     fall asynchronously; write in flight may or may not have committed.
// TESTING
//   1 CPU read addr 8'h10, mem returns 32'h0000_0005 after 1 cycle -> cpu_ack one
//     cycle, cpu_rdata=5, vid_ack=0, timeout_err=0.
//   2 cpu_req & vid_req high same edge after reset, both writes -> CPU served
//     first, VID next; mem_addr sequence CPU,VID; both acks one pulse each.
//   3 Both requesters continuously re-request 4 times -> grants alternate
//     C,V,C,V,C,V,C,V; no starvation.
//   4 VID write addr 8'h20 data 32'hCAFEF00D -> mem_wr_en=1, mem_wdata matches
//     for whole BUSY; vid_rdata unchanged.
//   5 Memory never acks -> after TIMEOUT=16 BUSY cycles owner ack pulses,
//     rdata=32'hDEADBEEF, timeout_err=1 and stays 1 through later good transfers.
//   6 Assert reset during BUSY -> all outputs 0 same cycle, no ack pulse; after
//     release with both reqs high, CPU granted first.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU data
// port and the video/debug DMA port. One transaction in flight at a time, with
// a watchdog that forces completion if the memory never acknowledges.
module dmem_arbiter #(
  parameter int          AW       = 8,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_wr_en,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_ack,
  input  logic          vid_req,
  input  logic          vid_wr_en,
  input  logic [AW-1:0] vid_addr,
  input  logic [31:0]   vid_wdata,
  output logic [31:0]   vid_rdata,
  output logic          vid_ack,
  output logic          mem_req,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack,
  output logic          timeout_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_VID = 1'b1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_grant_q, last_grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_wr_en_q, mem_wr_en_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [31:0]     cpu_rdata_q, cpu_rdata_d;
  logic [31:0]     vid_rdata_q, vid_rdata_d;
  logic            cpu_ack_q, cpu_ack_d;
  logic            vid_ack_q, vid_ack_d;
  logic            timeout_err_q, timeout_err_d;
  logic            winner;

  // Next-state and next-output computation for the IDLE -> BUSY -> DONE sequence.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    mem_req_d     = mem_req_q;
    mem_wr_en_d   = mem_wr_en_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    cpu_rdata_d   = cpu_rdata_q;
    vid_rdata_d   = vid_rdata_q;
    cpu_ack_d     = 1'b0;
    vid_ack_d     = 1'b0;
    timeout_err_d = timeout_err_q;
    winner        = OWN_CPU;

    case (state_q)
      IDLE: begin
        // On contention the side that did not win last time gets the memory.
        if (cpu_req && vid_req) begin
          winner = (last_grant_q == OWN_CPU) ? OWN_VID : OWN_CPU;
        end else begin
          winner = cpu_req ? OWN_CPU : OWN_VID;
        end
        if (cpu_req || vid_req) begin
          owner_d      = winner;
          last_grant_d = winner;
          cnt_d        = '0;
          mem_req_d    = 1'b1;
          mem_wr_en_d  = (winner == OWN_CPU) ? cpu_wr_en : vid_wr_en;
          mem_addr_d   = (winner == OWN_CPU) ? cpu_addr  : vid_addr;
          mem_wdata_d  = (winner == OWN_CPU) ? cpu_wdata : vid_wdata;
          state_d      = BUSY;
        end
      end

      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        // A real ack takes priority over a watchdog expiry in the same cycle.
        if (mem_ack || (cnt_q == CW'(TIMEOUT - 1))) begin
          if (mem_ack) begin
            if (!mem_wr_en_q) begin
              if (owner_q == OWN_CPU) cpu_rdata_d = mem_rdata;
              else                    vid_rdata_d = mem_rdata;
            end
          end else begin
            if (owner_q == OWN_CPU) cpu_rdata_d = ERR_DATA;
            else                    vid_rdata_d = ERR_DATA;
            timeout_err_d = 1'b1;
          end
          cpu_ack_d   = (owner_q == OWN_CPU);
          vid_ack_d   = (owner_q == OWN_VID);
          mem_req_d   = 1'b0;
          mem_wr_en_d = 1'b0;
          state_d     = DONE;
        end
      end

      DONE: begin
        // Requests are ignored here; the requester drops req on seeing ack.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= OWN_CPU;
      last_grant_q  <= OWN_VID;
      cnt_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      cpu_rdata_q   <= '0;
      vid_rdata_q   <= '0;
      cpu_ack_q     <= 1'b0;
      vid_ack_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      mem_req_q     <= mem_req_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      cpu_rdata_q   <= cpu_rdata_d;
      vid_rdata_q   <= vid_rdata_d;
      cpu_ack_q     <= cpu_ack_d;
      vid_ack_q     <= vid_ack_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign vid_rdata   = vid_rdata_q;
  assign cpu_ack     = cpu_ack_q;
  assign vid_ack     = vid_ack_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural memory with programmable wait
// states, two requester tasks, and a log of addresses presented to memory.
module tb_dmem_arbiter;

  localparam int AW = 8;

  logic          clk, reset;
  logic          cpu_req, cpu_wr_en, vid_req, vid_wr_en;
  logic [AW-1:0] cpu_addr, vid_addr;
  logic [31:0]   cpu_wdata, vid_wdata, cpu_rdata, vid_rdata;
  logic          cpu_ack, vid_ack;
  logic          mem_req, mem_wr_en, mem_ack, timeout_err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem_arr [0:255];
  int          lat = 0;
  bit          noack = 0;
  logic [7:0]  grant_log [$];

  dmem_arbiter #(.AW(AW), .TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_wr_en(vid_wr_en), .vid_addr(vid_addr),
    .vid_wdata(vid_wdata), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
    .mem_req(mem_req), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: acks after 'lat' wait cycles, one-cycle ack pulse.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
        wcnt = 0;
      end else if (mem_req && !noack) begin
        if (wcnt >= lat) begin
          mem_ack = 1'b1;
          if (mem_wr_en) mem_arr[mem_addr] = mem_wdata;
          else           mem_rdata = mem_arr[mem_addr];
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Record the address of each new memory request.
  initial begin
    forever begin
      @(posedge mem_req);
      #1;
      grant_log.push_back(mem_addr);
    end
  end

  task automatic cpu_txn(input logic wr, input logic [7:0] a, input logic [31:0] d,
                         input bit drop, output logic [31:0] rd, output int busy);
    bit got;
    got = 0; busy = 0; rd = '0;
    cpu_req = 1'b1; cpu_wr_en = wr; cpu_addr = a; cpu_wdata = d;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (cpu_ack) got = 1;
      else if (mem_req) busy++;
    end
    if (!got) chk("cpu_ack_seen", 32'd0, 32'd1);
    else begin
      rd = cpu_rdata;
      chk("cpu_other_ack", {31'd0, vid_ack}, 32'd0);
    end
    if (drop) cpu_req = 1'b0;
    @(negedge clk);
    chk("cpu_ack_pulse", {31'd0, cpu_ack}, 32'd0);
  endtask

  task automatic vid_txn(input logic wr, input logic [7:0] a, input logic [31:0] d,
                         input bit drop, output logic [31:0] rd, output int busy);
    bit got;
    got = 0; busy = 0; rd = '0;
    vid_req = 1'b1; vid_wr_en = wr; vid_addr = a; vid_wdata = d;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (vid_ack) got = 1;
      else if (mem_req) busy++;
    end
    if (!got) chk("vid_ack_seen", 32'd0, 32'd1);
    else begin
      rd = vid_rdata;
      chk("vid_other_ack", {31'd0, cpu_ack}, 32'd0);
    end
    if (drop) vid_req = 1'b0;
    @(negedge clk);
    chk("vid_ack_pulse", {31'd0, vid_ack}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd_c, rd_v, vid_before;
    logic [31:0] rd_c3 [4];
    logic [31:0] rd_v3 [4];
    int busy_c, busy_v, bad, acks;
    bit found;

    for (int i = 0; i < 256; i++) mem_arr[i] = {4{i[7:0]}};
    mem_arr[8'h10] = 32'h0000_0005;
    reset = 1'b1;
    cpu_req = 0; cpu_wr_en = 0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 0; vid_wr_en = 0; vid_addr = '0; vid_wdata = '0;
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_acks", {30'd0, cpu_ack, vid_ack}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_vid_rdata", vid_rdata, 32'd0);
    chk("rst_terr", {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1: CPU read with one wait cycle
    lat = 1;
    cpu_txn(1'b0, 8'h10, 32'd0, 1'b1, rd_c, busy_c);
    chk("t1_rdata", rd_c, 32'h0000_0005);
    chk("t1_busy", 32'(busy_c), 32'd2);
    chk("t1_terr", {31'd0, timeout_err}, 32'd0);

    // 2: simultaneous writes right after reset, zero-wait memory
    do_reset();
    lat = 0;
    grant_log.delete();
    fork
      cpu_txn(1'b1, 8'h30, 32'h1111_2222, 1'b1, rd_c, busy_c);
      vid_txn(1'b1, 8'h40, 32'h3333_4444, 1'b1, rd_v, busy_v);
    join
    chk("t2_first", {24'd0, grant_log.size() > 0 ? grant_log[0] : 8'hxx}, 32'h30);
    chk("t2_second", {24'd0, grant_log.size() > 1 ? grant_log[1] : 8'hxx}, 32'h40);
    chk("t2_cpu_busy", 32'(busy_c), 32'd1);
    chk("t2_mem30", mem_arr[8'h30], 32'h1111_2222);
    chk("t2_mem40", mem_arr[8'h40], 32'h3333_4444);

    // 3: both requesters re-request continuously, four reads each
    grant_log.delete();
    fork
      for (int i = 0; i < 4; i++)
        cpu_txn(1'b0, 8'h50 + 8'(i), 32'd0, i == 3, rd_c3[i], busy_c);
      for (int j = 0; j < 4; j++)
        vid_txn(1'b0, 8'h60 + 8'(j), 32'd0, j == 3, rd_v3[j], busy_v);
    join
    chk("t3_count", 32'(grant_log.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] exp_a;
      exp_a = (k % 2 == 0) ? 8'h50 + 8'(k / 2) : 8'h60 + 8'(k / 2);
      chk($sformatf("t3_grant%0d", k),
          {24'd0, k < grant_log.size() ? grant_log[k] : 8'hxx}, {24'd0, exp_a});
    end
    chk("t3_cpu_rd3", rd_c3[3], 32'h5353_5353);
    chk("t3_vid_rd0", rd_v3[0], 32'h6060_6060);

    // 4: VID write with wait states; memory-side signals stable through BUSY
    lat = 3;
    vid_before = vid_rdata;
    bad = 0;
    fork
      vid_txn(1'b1, 8'h20, 32'hCAFEF00D, 1'b1, rd_v, busy_v);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (mem_req && (mem_wr_en !== 1'b1 || mem_wdata !== 32'hCAFEF00D || mem_addr !== 8'h20))
          bad++;
      end
    join
    chk("t4_busy", 32'(busy_v), 32'd4);
    chk("t4_bad", 32'(bad), 32'd0);
    chk("t4_mem20", mem_arr[8'h20], 32'hCAFEF00D);
    chk("t4_vid_rdata", vid_rdata, vid_before);

    // 5: memory never acks -> watchdog completion, sticky error
    noack = 1;
    cpu_txn(1'b0, 8'h11, 32'd0, 1'b1, rd_c, busy_c);
    noack = 0;
    chk("t5_busy", 32'(busy_c), 32'd16);
    chk("t5_rdata", rd_c, 32'hDEADBEEF);
    chk("t5_terr", {31'd0, timeout_err}, 32'd1);
    lat = 0;
    cpu_txn(1'b0, 8'h12, 32'd0, 1'b1, rd_c, busy_c);
    chk("t5_good_rdata", rd_c, 32'h1212_1212);
    chk("t5_terr_sticky", {31'd0, timeout_err}, 32'd1);

    // 6: reset during BUSY aborts without ack; CPU wins first afterwards
    lat = 5;
    cpu_req = 1'b1; cpu_wr_en = 1'b0; cpu_addr = 8'h66;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_req) found = 1;
    end
    chk("t6_busy_reached", {31'd0, found}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    vid_req = 1'b1; vid_wr_en = 1'b0; vid_addr = 8'h77;
    #1;
    chk("t6_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t6_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("t6_terr", {31'd0, timeout_err}, 32'd0);
    acks = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (cpu_ack || vid_ack) acks++;
    end
    chk("t6_no_ack", 32'(acks), 32'd0);
    grant_log.delete();
    lat = 0;
    reset = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (cpu_ack) found = 1;
    end
    chk("t6_cpu_ack", {31'd0, found}, 32'd1);
    chk("t6_cpu_rdata", cpu_rdata, 32'h6666_6666);
    cpu_req = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (vid_ack) found = 1;
    end
    chk("t6_vid_ack", {31'd0, found}, 32'd1);
    vid_req = 1'b0;
    chk("t6_first", {24'd0, grant_log.size() > 0 ? grant_log[0] : 8'hxx}, 32'h66);
    chk("t6_second", {24'd0, grant_log.size() > 1 ? grant_log[1] : 8'hxx}, 32'h77);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
